barcodescanner_nios_switch_ctrl: RTL and testbench
==================================================

BARCODESCANNER_NIOS_SWITCH_CTRL -- requirements
Module: barcodescanner_nios_switch_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of switch inputs.
REQ-002 Parameter DEFAULT_PERIOD, default 50000: reset value of the debounce period register, in clk cycles.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: reset; asynchronous and active-low.
REQ-005 Port address, input, 2: Avalon-MM slave word address.
REQ-006 Port chipselect, input, 1: slave select.
REQ-007 Port write_n, input, 1: active-low write strobe; write occurs when chipselect=1 and write_n=0.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port readdata, output, 32: registered read data.
REQ-010 Port in_port, input, WIDTH: raw asynchronous switch levels.
REQ-011 Port irq, output, 1: level interrupt request.

Function
REQ-012 Register map: 0 = debounced state (RO); 1 = period[15:0] (RW); 2 = irq_mask[WIDTH-1:0] (RW); 3 = edge_capture[WIDTH-1:0] (write-1-to-clear).
REQ-013 in_port passes through a 2-flop synchronizer before any other use; synchronizer flops reset to 0.
REQ-014 Prescaler: 16-bit counter counts 0..eff_period-1, then wraps to 0; tick asserts for the one cycle in which the counter equals eff_period-1.
REQ-015 eff_period = period, except period=0 is treated as 1, giving a tick every cycle.
REQ-016 A write to address 1 loads period and forces the prescaler to 0 on the same edge; no tick is produced in that cycle.
REQ-017 Each bit has a 2-bit agree counter: on a tick, if sync bit != stable bit, the counter increments; if equal, it clears to 0; between ticks it holds.
REQ-018 When a bit's agree counter is 2 and the next tick still sees a difference (3rd consecutive tick), stable bit <= sync bit, the agree counter clears, and edge_capture bit <= 1 on the same edge.
REQ-019 A single-tick glitch, or any tick with sync equal to stable, never changes the stable bit.
REQ-020 Both rising and falling debounced transitions set edge_capture.
REQ-021 A write to address 3 clears each edge_capture bit whose writedata bit is 1; if a set (REQ-018) and a clear hit the same bit on the same edge, the set wins.
REQ-022 irq = OR over (edge_capture & irq_mask), derived only from register outputs, with no input-to-output combinational path.
REQ-023 readdata is registered every cycle from the address-selected register, zero-extended to 32 bits, giving 1-cycle read latency; unimplemented bits read 0.
REQ-024 Reads have no side effects; reading address 3 does not clear it.
REQ-025 Writes to address 0 are ignored; writedata bits above the register width are ignored.

Reset
REQ-026 On reset_n=0, immediately and asynchronously: readdata=0, irq=0, stable state=0, edge_capture=0, irq_mask=0, period=DEFAULT_PERIOD, prescaler=0, all agree counters=0.
REQ-027 Reset asserted mid-debounce discards all partial agree counts; no edge is recorded for a transition in progress.
REQ-028 After release, the first tick occurs eff_period cycles after the first rising clk edge.

Verification
REQ-029 period=4, in_port 00->01 held -> state reads 0x01 three ticks later (about 12 cycles + 2 sync); edge_capture=0x01.
REQ-030 period=4, bit0 pulsed high for 5 cycles (exactly one tick) -> state stays 0x00, edge_capture stays 0x00.
REQ-031 irq_mask=0x01, bit0 edge -> irq=1; write 0x01 to address 3 -> irq=0 the next cycle; mask=0x00 with edge pending -> irq=0.
REQ-032 Write-1-to-clear coincident with a new debounced edge on the same bit -> bit remains 1.
REQ-033 period=0 -> tick every cycle; step held -> state updates 3 cycles after sync output; write period mid-count -> prescaler restarts at 0.
REQ-034 reset_n pulsed low during the 2nd agree tick -> all registers at REQ-026 values; held input requires 3 fresh ticks before state changes.

Source files
------------

// File: rtl/barcodescanner_nios_switch_ctrl.sv
// Debounced switch input port with an Avalon-MM slave register file.
// Debounced edges are latched into edge_capture and can raise a level irq.
module barcodescanner_nios_switch_ctrl #(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [15:0] RST_PERIOD = 16'(DEFAULT_PERIOD);

    localparam logic [1:0] A_STATE  = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_MASK   = 2'd2;
    localparam logic [1:0] A_EDGE   = 2'd3;

    // Synchronizer
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Prescaler and period
    logic [15:0] period_q;
    logic [15:0] period_d;
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic [15:0] eff_period;
    logic        tick;

    // Debounce state
    logic [WIDTH-1:0]      stable_q;
    logic [WIDTH-1:0]      stable_d;
    logic [WIDTH-1:0][1:0] agree_q;
    logic [WIDTH-1:0][1:0] agree_d;
    logic [WIDTH-1:0]      edge_set;

    // Register file
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] ecap_q;
    logic [WIDTH-1:0] ecap_d;
    logic [WIDTH-1:0] ecap_clr;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;

    // Bus decode
    logic wr_en;
    logic wr_period;
    logic wr_mask;
    logic wr_edge;

    // Upper write bits have no register behind them
    logic unused_wd;

    assign unused_wd = ^writedata[31:16];

    assign wr_en     = chipselect & ~write_n;
    assign wr_period = wr_en && (address == A_PERIOD);
    assign wr_mask   = wr_en && (address == A_MASK);
    assign wr_edge   = wr_en && (address == A_EDGE);

    // A period of zero behaves like one: tick every cycle
    assign eff_period = (period_q == 16'd0) ? 16'd1 : period_q;

    // Suppressed on a period write so the restart is clean
    assign tick = (presc_q == (eff_period - 16'd1)) && !wr_period;

    // Two-flop synchronizer for the raw switch levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler wrap and period load
    always_comb begin
        presc_d  = presc_q + 16'd1;
        period_d = period_q;
        if (wr_period) begin
            period_d = writedata[15:0];
            presc_d  = 16'd0;
        end else if (tick) begin
            presc_d  = 16'd0;
        end
    end

    // Per-bit agree counters; third consecutive differing tick commits
    always_comb begin
        stable_d = stable_q;
        agree_d  = agree_q;
        edge_set = '0;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (agree_q[i] == 2'd2) begin
                        stable_d[i] = sync2_q[i];
                        agree_d[i]  = 2'd0;
                        edge_set[i] = 1'b1;
                    end else begin
                        agree_d[i] = agree_q[i] + 2'd1;
                    end
                end else begin
                    agree_d[i] = 2'd0;
                end
            end
        end
    end

    // Mask write and edge capture; a new edge beats a clear
    always_comb begin
        mask_d   = wr_mask ? writedata[WIDTH-1:0] : mask_q;
        ecap_clr = wr_edge ? writedata[WIDTH-1:0] : '0;
        ecap_d   = (ecap_q & ~ecap_clr) | edge_set;
    end

    // Read mux, zero-extended, captured every cycle
    always_comb begin
        rdata_d = 32'd0;
        unique case (address)
            A_STATE:  rdata_d = 32'(stable_q);
            A_PERIOD: rdata_d = 32'(period_q);
            A_MASK:   rdata_d = 32'(mask_q);
            A_EDGE:   rdata_d = 32'(ecap_q);
            default:  rdata_d = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= RST_PERIOD;
            presc_q  <= 16'd0;
            stable_q <= '0;
            agree_q  <= '0;
            mask_q   <= '0;
            ecap_q   <= '0;
            rdata_q  <= 32'd0;
        end else begin
            period_q <= period_d;
            presc_q  <= presc_d;
            stable_q <= stable_d;
            agree_q  <= agree_d;
            mask_q   <= mask_d;
            ecap_q   <= ecap_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_barcodescanner_nios_switch_ctrl.sv
// Bench for the debounced switch port: directed cases with literal
// expectations, then random traffic checked against a behavioural model.
module tb_barcodescanner_nios_switch_ctrl;

    localparam int W    = 8;
    localparam int DEFP = 50000;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    barcodescanner_nios_switch_ctrl #(
        .WIDTH(W),
        .DEFAULT_PERIOD(DEFP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [W-1:0]  m_s1, m_s2, m_stable, m_ec, m_mask, m_set, m_clr;
    logic [15:0]   m_period;
    logic [31:0]   m_rd;
    int            m_phase, m_eff;
    int            m_run [W];
    bit            m_wr, m_tick;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: sync delay of two, tick every eff cycles since restart,
    // a bit commits after three consecutive differing ticks.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_ec = '0; m_mask = '0;
            m_period = 16'(DEFP); m_phase = 0; m_rd = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_wr   = chipselect && !write_n;
            m_eff  = (m_period == 0) ? 1 : int'(m_period);
            m_tick = !(m_wr && address == 2'd1) && (m_phase == m_eff - 1);
            case (address)
                2'd0: m_rd = 32'(m_stable);
                2'd1: m_rd = 32'(m_period);
                2'd2: m_rd = 32'(m_mask);
                default: m_rd = 32'(m_ec);
            endcase
            m_set = '0;
            if (m_tick) begin
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] != m_stable[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == 3) begin
                            m_stable[i] = m_s2[i];
                            m_set[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_clr = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
            m_ec  = (m_ec & ~m_clr) | m_set;
            if (m_wr && address == 2'd2) m_mask = writedata[W-1:0];
            if (m_wr && address == 2'd1) begin
                m_period = writedata[15:0];
                m_phase  = 0;
            end else begin
                m_phase = (m_phase + 1) % m_eff;
            end
            m_s2 = m_s1;
            m_s1 = in_port;
        end
    end

    // Every-cycle comparison of the outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("readdata", readdata, m_rd);
            chk("irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step();
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp,
                          input string nm);
        step();
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        chipselect = 1'b0;
        @(negedge clk);
        chk(nm, readdata, exp);
    endtask

    logic [31:0] rnd;
    logic [15:0] rlo;
    bit          rst_pend;

    initial begin
        reset_n = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0; rst_pend = 0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1;

        // Reset values
        rd_chk(2'd1, 32'h0000_C350, "rst_period");
        rd_chk(2'd0, 32'h0, "rst_state");
        rd_chk(2'd2, 32'h0, "rst_mask");
        rd_chk(2'd3, 32'h0, "rst_edge");

        // Basic debounce of a held step
        wr(2'd1, 32'hABCD_0004);
        rd_chk(2'd1, 32'h4, "period_rw");
        in_port = 8'h01;
        repeat (30) step();
        rd_chk(2'd0, 32'h01, "step_state");
        rd_chk(2'd3, 32'h01, "step_edge");
        rd_chk(2'd3, 32'h01, "edge_read_keeps");
        wr(2'd0, 32'hFF);
        rd_chk(2'd0, 32'h01, "state_ro");
        wr(2'd3, 32'h01);
        rd_chk(2'd3, 32'h0, "w1c");

        // Short glitch on bit1 is rejected
        in_port = 8'h03;
        repeat (5) step();
        in_port = 8'h01;
        repeat (30) step();
        rd_chk(2'd0, 32'h01, "glitch_state");
        rd_chk(2'd3, 32'h0, "glitch_edge");

        // Interrupt behaviour
        wr(2'd2, 32'hFFFF_FF01);
        rd_chk(2'd2, 32'h01, "mask_rw");
        in_port = 8'h00;
        repeat (30) step();
        @(negedge clk);
        chk("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h01);
        @(negedge clk);
        chk("irq_clr", {31'b0, irq}, 32'h0);
        in_port = 8'h01;
        repeat (30) step();
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h0);
        @(negedge clk);
        chk("irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'hFF);

        // Clear coinciding with a new edge: the edge wins
        wr(2'd1, 32'h0);
        step();
        in_port = 8'h05;
        repeat (4) step();
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h04;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        rd_chk(2'd3, 32'h04, "set_beats_clr");

        // Period 0: state visible in readdata six edges after the input
        step();
        address = 2'd0; in_port = 8'h0D;
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge clk);
            chk("p0_latency", readdata, (k < 6) ? 32'h05 : 32'h0D);
        end

        // Period rewrite mid-count restarts the prescaler
        wr(2'd1, 32'h5);
        repeat (2) step();
        wr(2'd1, 32'h3);
        in_port = 8'h0C;
        repeat (20) step();

        // Reset in the middle of a debounce
        wr(2'd1, 32'h4);
        wr(2'd3, 32'hFF);
        in_port = 8'h0D;
        repeat (7) step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        rd_chk(2'd1, 32'h0000_C350, "mid_rst_period");
        rd_chk(2'd0, 32'h0, "mid_rst_state");
        rd_chk(2'd3, 32'h0, "mid_rst_edge");
        wr(2'd1, 32'h4);
        repeat (30) step();
        rd_chk(2'd0, 32'h0D, "post_rst_state");
        rd_chk(2'd3, 32'h0D, "post_rst_edge");

        // Random traffic
        wr(2'd1, 32'h2);
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rst_pend) begin
                reset_n = 1'b1;
                rst_pend = 0;
            end
            chipselect = 1'b0; write_n = 1'b1;
            address = 2'($urandom_range(0, 3));
            rnd = $urandom;
            if (rnd[7:0] < 8'd20) begin
                chipselect = 1'b1; write_n = 1'b0;
                writedata = $urandom;
                if (address == 2'd1) begin
                    rlo = 16'($urandom_range(0, 3));
                    writedata = {writedata[31:16], rlo};
                end
            end else if (rnd[7:0] < 8'd34) begin
                in_port[rnd[10:8]] = ~in_port[rnd[10:8]];
            end else if (rnd[7:0] == 8'd255 && rnd[15:12] == 4'd0) begin
                reset_n = 1'b0;
                rst_pend = 1;
            end
        end
        step();
        reset_n = 1'b1;
        chipselect = 1'b0; write_n = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
